shiftreg_frame_sequencer: RTL and testbench
===========================================

// Module: shiftreg_frame_sequencer
// PURPOSE
//  Sequences the serial shift-register output path: accepts parallel frames over a valid/ready
//  handshake and serialises each frame onto SDO. Drives a 1-cycle LATCH strobe per frame and
//  inserts a programmable inter-frame gap. Sits between the frame source and the SDO pin of top.
// PARAMETERS
//  WIDTH       16  bits per frame (>=2)
//  GAP_CYCLES  4   idle cycles between LATCH and next accept (0 allowed)
//  MSB_FIRST   1   1: frame_data[WIDTH-1] shifted first; 0: frame_data[0] first
// PORTS
//  CLK          in   1      system clock, all logic on rising edge
//  RST_N        in   1      asynchronous active-low reset
//  start_valid  in   1      frame_data valid
//  start_ready  out  1      sequencer can accept a frame (combinational from state only)
//  frame_data   in   WIDTH  parallel frame, sampled on accept
//  abort        in   1      synchronous abort of frame in flight
//  SDO          out  1      serial data out, driven directly from a flop
//  shift_en     out  1      high while SDO carries a valid bit
//  LATCH        out  1      1-cycle strobe after last bit of a completed frame
//  busy         out  1      high in every state except IDLE
//  frame_cnt    out  8      completed-frame counter, wraps 255->0
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, SDO=0, shift_en=0, LATCH=0, busy=0, frame_cnt=0,
//   internal shift reg and counters cleared. Reset mid-frame drops the frame; no LATCH issued.
//  States: IDLE, SHIFT, LATCH, GAP.
//  IDLE: start_ready=1. Accept = start_valid & start_ready & ~abort. On accept edge: shift reg
//   <= frame_data, SDO <= first bit, shift_en <= 1, bit_cnt <= WIDTH-1, -> SHIFT.
//  SHIFT: WIDTH cycles; cycle n (1..WIDTH after accept) shows bit n on SDO with shift_en=1.
//   bit_cnt decrements per cycle; at bit_cnt==0 -> LATCH, SDO<=0, shift_en<=0.
//  LATCH: exactly 1 cycle, LATCH=1, frame_cnt increments (mod 256) on leaving.
//   -> GAP if GAP_CYCLES>0, else -> IDLE.
//  GAP: GAP_CYCLES cycles, all outputs low except busy; -> IDLE.
//  Latency: first bit 1 cycle after accept; next accept earliest at cycle WIDTH+GAP_CYCLES+2.
//  start_ready is 0 outside IDLE; start_valid held during busy is not consumed (no lost frame,
//   no double accept); frame_data is not sampled outside the accept edge.
//  abort: priority over accept. In IDLE: blocks accept, no other effect. In SHIFT/LATCH/GAP:
//   next state IDLE, SDO=0, shift_en=0, no LATCH pulse, frame_cnt unchanged (abort during
//   LATCH cycle still suppresses nothing already driven but blocks the increment).
//  LSB-first (MSB_FIRST=0) mirrors bit order only; timing identical.
//  No X on any output after reset; SDO=0 whenever shift_en=0.
// TESTING (WIDTH=8, GAP_CYCLES=2, MSB_FIRST=1 unless stated)
//  1 Accept 8'hA5 at edge 0 -> SDO 1,0,1,0,0,1,0,1 cycles 1-8 with shift_en=1; LATCH=1 cycle 9;
//    start_ready=1 again cycle 12; frame_cnt=1.
//  2 start_valid held high with 8'hFF,8'h00 back-to-back -> two frames, 12-cycle spacing,
//    no extra accept during busy, frame_cnt=2.
//  3 abort at cycle 4 of 8'hC3 frame -> IDLE next cycle, SDO=0, no LATCH, frame_cnt unchanged;
//    next accept completes normally.
//  4 RST_N low at cycle 5 of a frame -> all outputs 0 immediately (before next CLK edge);
//    after release a new frame 8'h3C shifts correctly.
//  5 MSB_FIRST=0, 8'h01 -> SDO 1,0,0,0,0,0,0,0; GAP_CYCLES=0 -> start_ready in cycle 10.
//  6 256 completed frames -> frame_cnt wraps 255->0 on the 256th LATCH.

Source files
------------

// File: rtl/shiftreg_frame_sequencer.sv
// Serial shift-register output sequencer.
// Accepts a parallel frame over a valid/ready handshake and shifts it out on SDO.
// After the last bit it pulses LATCH for one cycle, then waits GAP_CYCLES idle cycles.
// abort returns to IDLE without a LATCH pulse and without counting the frame.
module shiftreg_frame_sequencer #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] frame_data,
  input  logic             abort,
  output logic             SDO,
  output logic             shift_en,
  output logic             LATCH,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sdo_q, sdo_d;
  logic             shen_q, shen_d;
  logic             latch_q, latch_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             accept_s;

  // Bit that leaves the register next, depending on shift direction.
  function automatic logic head_bit(input logic [WIDTH-1:0] data);
    if (MSB_FIRST) begin
      return data[WIDTH-1];
    end else begin
      return data[0];
    end
  endfunction

  // Register contents after the head bit has been consumed (zero fill).
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] data);
    if (MSB_FIRST) begin
      return {data[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, data[WIDTH-1:1]};
    end
  endfunction

  // Handshake and status are decoded from the state register only.
  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign accept_s    = start_valid & start_ready & ~abort;

  assign SDO       = sdo_q;
  assign shift_en  = shen_q;
  assign LATCH     = latch_q;
  assign frame_cnt = frame_cnt_q;

  // Next-state and next-output logic; SDO/shift_en/LATCH default low every cycle.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    sdo_d       = 1'b0;
    shen_d      = 1'b0;
    latch_d     = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d   = S_SHIFT;
          sr_d      = advance(frame_data);
          sdo_d     = head_bit(frame_data);
          shen_d    = 1'b1;
          bit_cnt_d = BIT_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d   = S_IDLE;
          sr_d      = {WIDTH{1'b0}};
          bit_cnt_d = {CW{1'b0}};
        end else if (bit_cnt_q == {CW{1'b0}}) begin
          state_d = S_LATCH;
          latch_d = 1'b1;
          sr_d    = {WIDTH{1'b0}};
        end else begin
          sdo_d     = head_bit(sr_q);
          sr_d      = advance(sr_q);
          shen_d    = 1'b1;
          bit_cnt_d = bit_cnt_q - BIT_ONE;
        end
      end
      S_LATCH: begin
        // An abort here cannot retract the strobe already on LATCH, but the frame is not counted.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (GAP_CYCLES > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_IDLE;
          gap_cnt_d = {GW{1'b0}};
        end else if (gap_cnt_q == {GW{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      sr_q        <= {WIDTH{1'b0}};
      sdo_q       <= 1'b0;
      shen_q      <= 1'b0;
      latch_q     <= 1'b0;
      bit_cnt_q   <= {CW{1'b0}};
      gap_cnt_q   <= {GW{1'b0}};
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sdo_q       <= sdo_d;
      shen_q      <= shen_d;
      latch_q     <= latch_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_frame_sequencer.sv
// Bench for shiftreg_frame_sequencer: scoreboard of completed frames plus directed timing checks.
module tb_shiftreg_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=8, GAP_CYCLES=2, MSB first.
  logic       sv = 1'b0, ab = 1'b0;
  logic [7:0] fd = 8'h00;
  logic       rdy, sdo, se, la, bz;
  logic [7:0] fc;

  // Second instance: WIDTH=8, GAP_CYCLES=0, LSB first.
  logic       sv2 = 1'b0, ab2 = 1'b0;
  logic [7:0] fd2 = 8'h00;
  logic       rdy2, sdo2, se2, la2, bz2;
  logic [7:0] fc2;

  shiftreg_frame_sequencer #(.WIDTH(8), .GAP_CYCLES(2), .MSB_FIRST(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .start_valid(sv), .start_ready(rdy), .frame_data(fd),
    .abort(ab), .SDO(sdo), .shift_en(se), .LATCH(la), .busy(bz), .frame_cnt(fc)
  );

  shiftreg_frame_sequencer #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b0)) dut2 (
    .CLK(clk), .RST_N(rst_n), .start_valid(sv2), .start_ready(rdy2), .frame_data(fd2),
    .abort(ab2), .SDO(sdo2), .shift_en(se2), .LATCH(la2), .busy(bz2), .frame_cnt(fc2)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wait (bounded) until the main instance is ready, sampled on a falling edge.
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, rdy}, 32'd1);
  endtask

  // Offer one frame; returns just after the accept edge (cycle 1).
  task automatic send(input logic [7:0] d, input bit completes);
    wait_ready();
    sv = 1'b1;
    fd = d;
    @(posedge clk);
    if (completes) begin
      exp_cnt = exp_cnt + 8'd1;
      sb.push_back('{d, exp_cnt});
    end
    #1 sv = 1'b0;
  endtask

  // Monitor: collects SDO bits, on each LATCH pops the scoreboard and checks word, length and count.
  logic [7:0] acc;
  int         nbits;
  logic       prev_se;
  logic       cnt_pending;
  logic [7:0] pend_cnt;
  exp_t       e;
  initial begin
    acc = 8'h00; nbits = 0; prev_se = 1'b0; cnt_pending = 1'b0; pend_cnt = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!se) begin
          chk("sdo_low_when_idle", {31'd0, sdo}, 32'd0);
        end else begin
          if (!prev_se) begin
            acc = 8'h00;
            nbits = 0;
          end
          acc = {acc[6:0], sdo};
          nbits++;
        end
        if (cnt_pending) begin
          chk("frame_cnt", {24'd0, fc}, {24'd0, pend_cnt});
          cnt_pending = 1'b0;
        end
        if (la) begin
          if (sb.size() == 0) begin
            chk("unexpected_latch", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("frame_word", {24'd0, acc}, {24'd0, e.data});
            chk("frame_bits", nbits, 32'd8);
            pend_cnt = e.cnt;
            cnt_pending = 1'b1;
          end
        end
        prev_se = se;
      end else begin
        prev_se = 1'b0;
        cnt_pending = 1'b0;
      end
    end
  end

  logic [7:0] d;

  initial begin
    // Reset state.
    #2;
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_shift_en", {31'd0, se}, 32'd0);
    chk("rst_latch", {31'd0, la}, 32'd0);
    chk("rst_busy", {31'd0, bz}, 32'd0);
    chk("rst_frame_cnt", {24'd0, fc}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: single frame A5, timing of bits, LATCH and ready.
    d = 8'hA5;
    send(d, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        chk("t1_shift_en", {31'd0, se}, 32'd1);
        chk("t1_sdo", {31'd0, sdo}, {31'd0, d[8-n]});
      end
      if (n == 9)  chk("t1_latch", {31'd0, la}, 32'd1);
      if (n == 11) chk("t1_ready_gap", {31'd0, rdy}, 32'd0);
      if (n == 12) begin
        chk("t1_ready_back", {31'd0, rdy}, 32'd1);
        chk("t1_frame_cnt", {24'd0, fc}, 32'd1);
      end
    end

    // 2: start_valid held with FF then 00; second accept exactly 12 cycles later.
    wait_ready();
    sv = 1'b1;
    fd = 8'hFF;
    @(posedge clk);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{8'hFF, exp_cnt});
    #1 fd = 8'h00;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 11) chk("t2_no_accept_busy", {31'd0, rdy}, 32'd0);
      if (n == 12) begin
        chk("t2_ready", {31'd0, rdy}, 32'd1);
        chk("t2_idle_se", {31'd0, se}, 32'd0);
      end
    end
    @(posedge clk);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back('{8'h00, exp_cnt});
    #1 sv = 1'b0;
    @(negedge clk);
    chk("t2_second_start", {31'd0, se}, 32'd1);
    chk("t2_second_busy", {31'd0, bz}, 32'd1);

    // abort in IDLE blocks the accept.
    wait_ready();
    sv = 1'b1;
    ab = 1'b1;
    fd = 8'h77;
    @(posedge clk);
    #1 begin sv = 1'b0; ab = 1'b0; end
    @(negedge clk);
    chk("idle_abort_busy", {31'd0, bz}, 32'd0);
    chk("idle_abort_se", {31'd0, se}, 32'd0);

    // 3: abort in cycle 4 of C3.
    send(8'hC3, 1'b0);
    repeat (3) @(posedge clk);
    #1 ab = 1'b1;
    @(posedge clk);
    #1 ab = 1'b0;
    @(negedge clk);
    chk("t3_busy", {31'd0, bz}, 32'd0);
    chk("t3_ready", {31'd0, rdy}, 32'd1);
    chk("t3_se", {31'd0, se}, 32'd0);
    chk("t3_sdo", {31'd0, sdo}, 32'd0);
    chk("t3_frame_cnt", {24'd0, fc}, {24'd0, exp_cnt});
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("t3_no_latch", {31'd0, la}, 32'd0);
    end
    send(8'h5A, 1'b1);

    // 4: asynchronous reset in cycle 5 of a frame.
    send(8'h96, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t4_sdo", {31'd0, sdo}, 32'd0);
    chk("t4_se", {31'd0, se}, 32'd0);
    chk("t4_latch", {31'd0, la}, 32'd0);
    chk("t4_busy", {31'd0, bz}, 32'd0);
    chk("t4_frame_cnt", {24'd0, fc}, 32'd0);
    exp_cnt = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send(8'h3C, 1'b1);

    // 5: LSB-first instance with no gap.
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 8'h01 : 8'h96;
      @(negedge clk);
      sv2 = 1'b1;
      fd2 = d;
      @(posedge clk);
      #1 sv2 = 1'b0;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (n <= 8) begin
          chk("t5_shift_en", {31'd0, se2}, 32'd1);
          chk("t5_sdo", {31'd0, sdo2}, {31'd0, d[n-1]});
        end
        if (n == 9) begin
          chk("t5_latch", {31'd0, la2}, 32'd1);
          chk("t5_ready_latch", {31'd0, rdy2}, 32'd0);
        end
        if (n == 10) begin
          chk("t5_ready", {31'd0, rdy2}, 32'd1);
          chk("t5_frame_cnt", {24'd0, fc2}, k + 1);
        end
      end
    end

    // 6: frame counter wraps on the 256th completed frame since reset.
    for (int i = 0; i < 255; i++) begin
      send(8'(i * 37 + 11), 1'b1);
    end
    repeat (20) @(negedge clk);
    chk("t6_wrap", {24'd0, fc}, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
